// File: rtl/rca_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : rca_pipe_addsub
// Description : Pipelined ripple-carry add/subtract unit. The DATA_SIZE-bit
//               operation is split into STAGES slices of W = DATA_SIZE/STAGES
//               bits. Each cycle one slice is rippled and its carry-out is
//               registered for the next slice. Both the operand side and the
//               result side use a valid/ready handshake.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               add_1, add_2      - operands A and B
//               c_in, sub         - carry/borrow-in, 0:A+B+c_in 1:A-B-c_in
//               valid_f_data      - operand bundle valid
//               ready_f_data      - operand bundle accepted this cycle
//               s, c_out, ovf     - result, raw MSB carry, signed overflow
//               valid_f_res       - result bundle valid
//               ready_f_res       - consumer takes the result this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rca_pipe_addsub #(
    parameter int DATA_SIZE = 16,
    parameter int STAGES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] add_1,
    input  logic [DATA_SIZE-1:0] add_2,
    input  logic                 c_in,
    input  logic                 sub,
    input  logic                 valid_f_data,
    output logic                 ready_f_data,
    output logic [DATA_SIZE-1:0] s,
    output logic                 c_out,
    output logic                 ovf,
    output logic                 valid_f_res,
    input  logic                 ready_f_res
);

    localparam int W    = DATA_SIZE / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = DATA_SIZE - 1;

    // Per-stage registered state. x_q mixes two things in one vector: the
    // untouched upper A bits and the already-computed lower sum bits. Slice k
    // overwrites its own A bits with sum bits, so after the last stage x_q
    // holds the complete result. y_q carries B' (already inverted for SUB).
    logic [DATA_SIZE-1:0] x_q   [STAGES];
    logic [DATA_SIZE-1:0] y_q   [STAGES];
    logic [STAGES-1:0]    c_q;
    logic [STAGES-1:0]    v_q;
    logic                 ovf_q;

    // Stage inputs and next-state values
    logic [DATA_SIZE-1:0] in_x  [STAGES];
    logic [DATA_SIZE-1:0] in_y  [STAGES];
    logic [STAGES-1:0]    in_c;
    logic [STAGES-1:0]    in_v;
    logic [DATA_SIZE-1:0] x_d   [STAGES];
    logic [W:0]           slice [STAGES];
    logic [STAGES-1:0]    c_d;
    logic                 ovf_d;
    logic [STAGES-1:0]    adv;

    always_comb begin
        // Stage 0 takes the operand bundle; subtraction is mapped onto
        // addition as A + ~B + ~borrow.
        in_x[0] = add_1;
        in_y[0] = sub ? ~add_2 : add_2;
        in_c[0] = sub ? ~c_in : c_in;
        in_v[0] = valid_f_data;
        for (int k = 1; k < STAGES; k++) begin
            in_x[k] = x_q[k-1];
            in_y[k] = y_q[k-1];
            in_c[k] = c_q[k-1];
            in_v[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, in_x[k][k*W +: W]} + {1'b0, in_y[k][k*W +: W]}
                     + {{W{1'b0}}, in_c[k]};
            x_d[k]            = in_x[k];
            x_d[k][k*W +: W]  = slice[k][W-1:0];
            c_d[k]            = slice[k][W];
        end

        // The carry into the MSB is recovered from the MSB sum bit itself:
        // sum = a ^ b ^ cin  =>  cin = a ^ b ^ sum.
        ovf_d = (in_x[LAST][MSB] ^ in_y[LAST][MSB] ^ x_d[LAST][MSB]) ^ c_d[LAST];

        // A stage may load when it, or any stage downstream of it, is empty,
        // or when the consumer drains the output. This is the collapsed form
        // of "valid is 0 or the next stage loads", avoiding a self-referencing
        // chain in one vector.
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = ready_f_res;
            for (int j = k; j < STAGES; j++) begin
                if (!v_q[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= in_v[k];
                    // Data only moves with a valid token, so the output
                    // fields keep their last value once the pipe drains.
                    if (in_v[k]) begin
                        x_q[k] <= x_d[k];
                        y_q[k] <= in_y[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (adv[LAST] && in_v[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign ready_f_data = adv[0];
    assign s            = x_q[LAST];
    assign c_out        = c_q[LAST];
    assign ovf          = ovf_q;
    assign valid_f_res  = v_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_rca_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_pipe_addsub
// Description : Self-checking bench for rca_pipe_addsub (16 bits, 4 stages).
//               A queue of expected results is built from plain integer
//               arithmetic; an op is expected at the output once it has aged
//               STAGES-1 edges past its accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_pipe_addsub;

    localparam int DATA_SIZE = 16;
    localparam int STAGES    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_SIZE-1:0] add_1, add_2;
    logic                 c_in, sub, valid_f_data, ready_f_res;
    logic                 ready_f_data, c_out, ovf, valid_f_res;
    logic [DATA_SIZE-1:0] s;

    rca_pipe_addsub #(.DATA_SIZE(DATA_SIZE), .STAGES(STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .add_1        (add_1),
        .add_2        (add_2),
        .c_in         (c_in),
        .sub          (sub),
        .valid_f_data (valid_f_data),
        .ready_f_data (ready_f_data),
        .s            (s),
        .c_out        (c_out),
        .ovf          (ovf),
        .valid_f_res  (valid_f_res),
        .ready_f_res  (ready_f_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    exp_t q[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    int   cycle  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: unsigned for result/carry, signed range for ovf.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        exp_t e;
        int   ua, ub, sa, sbv, full, sv;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (!sb) begin
            full = ua + ub + int'(ci);
            sv   = sa + sbv + int'(ci);
            e.c  = (full >= 65536);
        end else begin
            full = ua - ub - int'(ci);
            sv   = sa - sbv - int'(ci);
            e.c  = (full >= 0);
        end
        e.s = full[15:0];
        e.o = (sv > 32767) || (sv < -32768);
        e.t = 0;
        return e;
    endfunction

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // update the model, then step past the rising edge.
    task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic rdy);
        logic exp_v, exp_rdy;
        exp_t e;
        valid_f_data = v;
        add_1        = a;
        add_2        = b;
        c_in         = ci;
        sub          = sb;
        ready_f_res  = rdy;
        #4;
        exp_v   = (q.size() > 0) && (cycle - q[0].t >= STAGES);
        exp_rdy = (q.size() < STAGES) || rdy;
        chk("valid_f_res", 32'(valid_f_res), 32'(exp_v));
        chk("ready_f_data", 32'(ready_f_data), 32'(exp_rdy));
        if (exp_v) begin
            chk("s", 32'(s), 32'(q[0].s));
            chk("c_out", 32'(c_out), 32'(q[0].c));
            chk("ovf", 32'(ovf), 32'(q[0].o));
            if (rdy) begin
                void'(q.pop_front());
            end
        end
        if (v && exp_rdy) begin
            e   = model(a, b, ci, sb);
            e.t = cycle;
            q.push_back(e);
        end
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    logic [15:0] ra, rb;

    initial begin
        rst          = 1'b1;
        add_1        = '0;
        add_2        = '0;
        c_in         = 1'b0;
        sub          = 1'b0;
        valid_f_data = 1'b0;
        ready_f_res  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_f_res", 32'(valid_f_res), 32'd0);
        chk("rst s", 32'(s), 32'd0);
        chk("rst c_out", 32'(c_out), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst ready_f_data", 32'(ready_f_data), 32'd1);

        // Directed arithmetic corner cases, each drained individually
        cyc(1'b1, 16'h002A, 16'h00C9, 1'b0, 1'b0, 1'b1); idle(5);
        cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); idle(5);
        cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); idle(5);
        cyc(1'b1, 16'h0008, 16'h0006, 1'b0, 1'b1, 1'b1); idle(5);
        cyc(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1); idle(5);
        cyc(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1); idle(5);
        cyc(1'b1, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b1); idle(5);
        cyc(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1); idle(5);

        // Streaming: 8 back-to-back ops with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        idle(6);

        // Backpressure: feed for 10 cycles with the consumer stalled
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        idle(8);

        // Async reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        rst = 1'b1;
        #1;
        chk("async rst valid_f_res", 32'(valid_f_res), 32'd0);
        chk("async rst s", 32'(s), 32'd0);
        q.delete();
        @(posedge clk);
        cycle++;
        #1;
        rst = 1'b0;
        cyc(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Random traffic with random producer/consumer stalls
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            cyc(1'($urandom_range(3, 0) != 0), ra, rb, 1'($urandom), 1'($urandom),
                1'($urandom_range(2, 0) != 0));
        end
        idle(8);
        chk("queue drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
